// File: rtl/heap_array_server.sv
// heap_array_server
// -----------------
// Single-outstanding request/response server for heap arrays. It owns the heap
// memory, the per-array size table, the per-array allocated bits and the LIFO
// stack of freed array numbers.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   req_valid    request present
//   req_ready    server idle and able to take a request
//   req_op       0 ALLOC, 1 FREE, 2 WRITE, 3 READ, 4 SIZE, 5..7 illegal
//   req_array    target array number (FREE/WRITE/READ/SIZE)
//   req_index    element index (WRITE/READ)
//   req_data     element value (WRITE)
//   rsp_valid    response present
//   rsp_ready    initiator takes the response
//   rsp_data     array number (ALLOC), element (READ), size (SIZE), else 0
//   rsp_error    request rejected, nothing was changed
//   allocs       number of arrays ever handed out fresh (high-water mark)
//   free_count   entries currently on the freed stack
module heap_array_server #(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 7,
    parameter int NArrays            = 4,
    parameter int NHeap              = 28
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [2:0]                    req_op,
    input  logic [MemoryElementWidth-1:0] req_array,
    input  logic [MemoryElementWidth-1:0] req_index,
    input  logic [MemoryElementWidth-1:0] req_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [MemoryElementWidth-1:0] rsp_data,
    output logic                          rsp_error,
    output logic [MemoryElementWidth-1:0] allocs,
    output logic [MemoryElementWidth-1:0] free_count
);

    localparam int W = MemoryElementWidth;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [2:0] OP_ALLOC = 3'd0;
    localparam logic [2:0] OP_FREE  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_READ  = 3'd3;
    localparam logic [2:0] OP_SIZE  = 3'd4;

    logic [1:0]   state;
    logic [2:0]   op_q;
    logic [W-1:0] array_q;
    logic [W-1:0] index_q;
    logic [W-1:0] data_q;

    logic [W-1:0] allocs_q;
    logic [W-1:0] free_count_q;
    logic [W-1:0] size_tab  [NArrays];
    logic         allocated [NArrays];
    logic [W-1:0] stack     [NArrays];
    logic [W-1:0] heap      [NHeap];

    logic [W-1:0] rsp_data_q;
    logic         rsp_error_q;

    logic         arr_allocated;
    logic [W-1:0] arr_size;
    logic [W-1:0] top_entry;
    logic [W-1:0] heap_word;
    logic [31:0]  heap_addr;
    logic [W-1:0] index_plus;

    logic         exec_error;
    logic [W-1:0] exec_data;
    logic [W-1:0] alloc_slot;
    logic         do_pop;
    logic         do_fresh;
    logic         do_free;
    logic         do_write;
    logic [W-1:0] new_size;

    assign req_ready  = (state == IDLE);
    assign rsp_valid  = (state == RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_error  = rsp_error_q;
    assign allocs     = allocs_q;
    assign free_count = free_count_q;

    // The heap address is formed at 32 bits so an out-of-range array or index
    // can never alias onto a legal word; it is only used after the checks pass.
    assign heap_addr  = 32'(array_q) * 32'(NArea) + 32'(index_q);
    assign index_plus = index_q + W'(1);

    // Table lookups compare the full-width captured number against each slot
    // rather than truncating it, so an array number >= NArrays matches nothing
    // and reads back as "not allocated".
    always_comb begin
        arr_allocated = 1'b0;
        arr_size      = '0;
        top_entry     = '0;
        heap_word     = '0;
        for (int i = 0; i < NArrays; i++) begin
            if (array_q == W'(i)) begin
                arr_allocated = allocated[i];
                arr_size      = size_tab[i];
            end
            if (free_count_q == W'(i + 1)) begin
                top_entry = stack[i];
            end
        end
        for (int i = 0; i < NHeap; i++) begin
            if (heap_addr == 32'(i)) begin
                heap_word = heap[i];
            end
        end
    end

    // Decode of the captured request into a response and a set of commit
    // strobes. Every error path leaves all strobes low so nothing changes.
    always_comb begin
        exec_error = 1'b1;
        exec_data  = '0;
        alloc_slot = '0;
        do_pop     = 1'b0;
        do_fresh   = 1'b0;
        do_free    = 1'b0;
        do_write   = 1'b0;
        new_size   = arr_size;
        case (op_q)
            OP_ALLOC: begin
                if (free_count_q != '0) begin
                    alloc_slot = top_entry;
                    do_pop     = 1'b1;
                    exec_error = 1'b0;
                    exec_data  = top_entry;
                end else if (allocs_q < W'(NArrays)) begin
                    alloc_slot = allocs_q;
                    do_fresh   = 1'b1;
                    exec_error = 1'b0;
                    exec_data  = allocs_q;
                end
            end
            OP_FREE: begin
                if (array_q < allocs_q && arr_allocated) begin
                    do_free    = 1'b1;
                    exec_error = 1'b0;
                end
            end
            OP_WRITE: begin
                if (arr_allocated && index_q < W'(NArea)) begin
                    do_write   = 1'b1;
                    exec_error = 1'b0;
                    if (index_plus > arr_size) begin
                        new_size = index_plus;
                    end
                end
            end
            OP_READ: begin
                if (arr_allocated && index_q < arr_size) begin
                    exec_error = 1'b0;
                    exec_data  = heap_word;
                end
            end
            OP_SIZE: begin
                if (arr_allocated) begin
                    exec_error = 1'b0;
                    exec_data  = arr_size;
                end
            end
            default: begin
                exec_error = 1'b1;
            end
        endcase
    end

    // Control, bookkeeping tables and response registers. All table updates
    // happen on the EXEC-to-RESP edge, so a later READ sees every earlier WRITE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            op_q         <= '0;
            array_q      <= '0;
            index_q      <= '0;
            data_q       <= '0;
            allocs_q     <= '0;
            free_count_q <= '0;
            rsp_data_q   <= '0;
            rsp_error_q  <= 1'b0;
            for (int i = 0; i < NArrays; i++) begin
                size_tab[i]  <= '0;
                allocated[i] <= 1'b0;
                stack[i]     <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        array_q <= req_array;
                        index_q <= req_index;
                        data_q  <= req_data;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= exec_data;
                    rsp_error_q <= exec_error;
                    state       <= RESP;
                    if (do_pop) begin
                        free_count_q <= free_count_q - W'(1);
                    end
                    if (do_fresh) begin
                        allocs_q <= allocs_q + W'(1);
                    end
                    if (do_free) begin
                        free_count_q <= free_count_q + W'(1);
                    end
                    for (int i = 0; i < NArrays; i++) begin
                        if ((do_pop || do_fresh) && alloc_slot == W'(i)) begin
                            allocated[i] <= 1'b1;
                            size_tab[i]  <= '0;
                        end
                        if (do_free && array_q == W'(i)) begin
                            allocated[i] <= 1'b0;
                        end
                        if (do_free && free_count_q == W'(i)) begin
                            stack[i] <= array_q;
                        end
                        if (do_write && array_q == W'(i)) begin
                            size_tab[i] <= new_size;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Heap storage has no reset; its contents are meaningless after reset
    // until written, which keeps it mappable onto a plain RAM.
    always_ff @(posedge clock) begin
        if (state == EXEC && do_write) begin
            for (int i = 0; i < NHeap; i++) begin
                if (heap_addr == 32'(i)) begin
                    heap[i] <= data_q;
                end
            end
        end
    end

endmodule
